// File: rtl/modexp_pkg.sv
// ---------------------------------------------------------------------------
// modexp_pkg
// Shared definitions for the parametrised modular exponentiation unit.
//   stateT    : controller states of the top-level FSM
//   cntWidth  : width of a counter that has to hold values 0 .. n-1
// ---------------------------------------------------------------------------
package modexp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    BITS,
    DONE
  } stateT;

  // A counter running from n-1 down to 1 needs clog2(n) bits; keep at least
  // one bit so degenerate widths still elaborate.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/modmul_interleaved.sv
// ---------------------------------------------------------------------------
// modmul_interleaved
// Bit-serial interleaved modular multiplier: R = A*B mod M, scanning A from
// its MSB down, one bit per clock. The first bit is processed on the go edge
// itself, so the result is ready after N edges and rdy is seen high N cycles
// after go.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   go         : load A/B/M and start a multiplication
//   A          : multiplier operand, any N-bit value
//   B          : multiplicand, must be < M
//   M          : modulus, must be non-zero
//   R          : running / final remainder, always < M
//   rdy        : one-cycle pulse when R holds the finished product
// ---------------------------------------------------------------------------
module modmul_interleaved
  import modexp_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         go,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] M,
  output logic [N-1:0] R,
  output logic         rdy
);

  localparam int CW = cntWidth(N);

  logic [N-1:0]  aReg;
  logic [N-1:0]  bReg;
  logic [N-1:0]  mReg;
  logic [N-1:0]  rReg;
  logic [CW-1:0] cnt;
  logic          active;

  // One interleaved step: double, reduce, conditionally add B, reduce.
  // With r < m and b < m every intermediate stays below 2m, so N+2 bits are
  // enough and each reduction needs only a single subtraction.
  function automatic logic [N-1:0] step(input logic [N-1:0] r,
                                        input logic         abit,
                                        input logic [N-1:0] b,
                                        input logic [N-1:0] m);
    logic [N+1:0] t;
    logic [N+1:0] mw;
    mw = {2'b00, m};
    t  = {1'b0, r, 1'b0};
    if (t >= mw) t = t - mw;
    if (abit) t = t + {2'b00, b};
    if (t >= mw) t = t - mw;
    return t[N-1:0];
  endfunction

  // Operand capture on go, then one step per cycle until all N bits of A
  // have been consumed; rdy is raised for exactly one cycle at the end.
  always_ff @(posedge clk) begin
    if (reset) begin
      aReg   <= '0;
      bReg   <= '0;
      mReg   <= '0;
      rReg   <= '0;
      cnt    <= '0;
      active <= 1'b0;
      rdy    <= 1'b0;
    end else begin
      rdy <= 1'b0;
      if (go) begin
        rReg   <= step('0, A[N-1], B, M);
        aReg   <= {A[N-2:0], 1'b0};
        bReg   <= B;
        mReg   <= M;
        cnt    <= CW'(N - 1);
        active <= 1'b1;
      end else if (active) begin
        rReg <= step(rReg, aReg[N-1], bReg, mReg);
        aReg <= {aReg[N-2:0], 1'b0};
        cnt  <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          active <= 1'b0;
          rdy    <= 1'b1;
        end
      end
    end
  end

  assign R = rReg;

endmodule

// File: rtl/modular_exp_param.sv
// ---------------------------------------------------------------------------
// modular_exp_param
// P = X^Y mod M using right-to-left square-and-multiply. A squarer and a
// multiplier (both modmul_interleaved) run side by side, so every exponent
// bit costs N cycles. The first N cycles reduce X modulo M by multiplying it
// by "one" on the multiply instance. Processing stops after the highest set
// bit of Y.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start      : request, only looked at in IDLE
//   X, Y, M    : base (any value), exponent, modulus
//   P          : result, held from the done cycle until the next result
//   busy       : high while an operation is in progress
//   done       : one-cycle completion pulse
//   err        : flagged with done when M == 0, cleared by the next start
// ---------------------------------------------------------------------------
module modular_exp_param
  import modexp_pkg::*;
#(
  parameter int N = 8,
  parameter int E = N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] X,
  input  logic [E-1:0] Y,
  input  logic [N-1:0] M,
  output logic [N-1:0] P,
  output logic         busy,
  output logic         done,
  output logic         err
);

  stateT        state;
  stateT        nextState;

  logic [E-1:0] yReg;
  logic [N-1:0] mReg;
  logic [N-1:0] oneReg;
  logic [N-1:0] resultReg;
  logic [N-1:0] pReg;
  logic         errReg;

  logic [N-1:0] oneIn;
  logic [N-1:0] nextBase;
  logic [N-1:0] nextResult;
  logic [N-1:0] mulA;
  logic [N-1:0] mulB;
  logic [N-1:0] mIn;
  logic [N-1:0] mulR;
  logic [N-1:0] sqR;
  logic         mulGo;
  logic         sqGo;
  logic         mulRdy;
  logic         sqRdy;
  logic         stepDone;
  logic         lastBit;

  // "one" is 0 for M == 1 so that every value, including the initial result,
  // is already reduced and M == 1 naturally produces P = 0.
  assign oneIn    = (M == N'(1)) ? '0 : N'(1);
  assign stepDone = mulRdy & sqRdy;
  assign lastBit  = ((yReg >> 1) == {E{1'b0}});

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic, multiplier operand steering and status outputs.
  // The multipliers are restarted on the same edge that finishes a step,
  // so their operands come straight from the values being registered.
  // X is consumed by the multiplier on the accept edge, which captures it.
  always_comb begin
    nextState  = state;
    mulGo      = 1'b0;
    sqGo       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    nextBase   = (state == BITS) ? sqR : mulR;
    nextResult = (state == BITS) ? (yReg[0] ? mulR : resultReg) : oneReg;
    mulA       = nextResult;
    mulB       = nextBase;
    mIn        = mReg;
    case (state)
      IDLE: begin
        mulA = X;
        mulB = oneIn;
        mIn  = M;
        if (start) begin
          if (M == '0) begin
            nextState = DONE;
          end else begin
            nextState = REDUCE;
            mulGo     = 1'b1;
          end
        end
      end
      REDUCE: begin
        busy = 1'b1;
        if (mulRdy) begin
          if (yReg == '0) begin
            nextState = DONE;
          end else begin
            nextState = BITS;
            mulGo     = 1'b1;
            sqGo      = 1'b1;
          end
        end
      end
      BITS: begin
        busy = 1'b1;
        if (stepDone) begin
          if (lastBit) begin
            nextState = DONE;
          end else begin
            mulGo = 1'b1;
            sqGo  = 1'b1;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Operand, exponent and result registers. P is loaded on the edge that
  // enters DONE so it is valid together with the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      yReg      <= '0;
      mReg      <= '0;
      oneReg    <= '0;
      resultReg <= '0;
      pReg      <= '0;
      errReg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            yReg   <= Y;
            mReg   <= M;
            oneReg <= oneIn;
            errReg <= (M == '0);
            if (M == '0) pReg <= '0;
          end
        end
        REDUCE: begin
          if (mulRdy) begin
            resultReg <= nextResult;
            if (yReg == '0) pReg <= nextResult;
          end
        end
        BITS: begin
          if (stepDone) begin
            resultReg <= nextResult;
            yReg      <= yReg >> 1;
            if (lastBit) pReg <= nextResult;
          end
        end
        default: ;
      endcase
    end
  end

  assign P   = pReg;
  assign err = errReg;

  modmul_interleaved #(.N(N)) uMul (
    .clk   (clk),
    .reset (reset),
    .go    (mulGo),
    .A     (mulA),
    .B     (mulB),
    .M     (mIn),
    .R     (mulR),
    .rdy   (mulRdy)
  );

  modmul_interleaved #(.N(N)) uSqr (
    .clk   (clk),
    .reset (reset),
    .go    (sqGo),
    .A     (nextBase),
    .B     (nextBase),
    .M     (mIn),
    .R     (sqR),
    .rdy   (sqRdy)
  );

endmodule

// File: tb/tb_modular_exp_param.sv
// ---------------------------------------------------------------------------
// tb_modular_exp_param
// Directed checks of an N=8 and an N=16 instance plus a reference-model sweep
// on the N=8 instance. Cycle numbering: cycle 1 is the first cycle after the
// edge that accepts start.
// ---------------------------------------------------------------------------
module tb_modular_exp_param;

  logic        clk = 1'b0;
  logic        reset;

  logic        start8;
  logic [7:0]  X8, Y8, M8, P8;
  logic        busy8, done8, err8;

  logic        start16;
  logic [15:0] X16, Y16, M16, P16;
  logic        busy16, done16, err16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  modular_exp_param #(.N(8), .E(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .start (start8),
    .X     (X8),
    .Y     (Y8),
    .M     (M8),
    .P     (P8),
    .busy  (busy8),
    .done  (done8),
    .err   (err8)
  );

  modular_exp_param #(.N(16), .E(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .start (start16),
    .X     (X16),
    .Y     (Y16),
    .M     (M16),
    .P     (P16),
    .busy  (busy16),
    .done  (done16),
    .err   (err16)
  );

  // Every comparison goes through here so the counters stay in one place.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Present an operation to the 8-bit instance; accepted on the next edge.
  task automatic applyStimulus8(input logic [7:0] x, input logic [7:0] y,
                                input logic [7:0] m);
    @(negedge clk);
    X8 = x; Y8 = y; M8 = m; start8 = 1'b1;
  endtask

  task automatic applyStimulus16(input logic [15:0] x, input logic [15:0] y,
                                 input logic [15:0] m);
    @(negedge clk);
    X16 = x; Y16 = y; M16 = m; start16 = 1'b1;
  endtask

  // Wait for done on the 8-bit instance, scrambling the inputs after the
  // accept edge and optionally pulsing start at cycle pulseAt. lat = -1 on
  // timeout; busyOk = busy high in every cycle before done and low at done.
  task automatic waitDone8(input int pulseAt, output int lat, output logic busyOk);
    lat    = 0;
    busyOk = 1'b1;
    while (lat < 2000) begin
      @(negedge clk);
      lat++;
      start8 = (lat == pulseAt);
      if (lat == 1 || lat == pulseAt) begin
        X8 = 8'($urandom); Y8 = 8'($urandom); M8 = 8'($urandom);
      end
      if (done8) begin
        if (busy8) busyOk = 1'b0;
        return;
      end
      if (!busy8) busyOk = 1'b0;
    end
    lat = -1;
  endtask

  task automatic waitDone16(output int lat, output logic busyOk);
    lat    = 0;
    busyOk = 1'b1;
    while (lat < 4000) begin
      @(negedge clk);
      lat++;
      start16 = 1'b0;
      if (lat == 1) begin
        X16 = 16'hFFFF; Y16 = 16'h1234; M16 = 16'h0007;
      end
      if (done16) begin
        if (busy16) busyOk = 1'b0;
        return;
      end
      if (!busy16) busyOk = 1'b0;
    end
    lat = -1;
  endtask

  function automatic int modpow(input int x, input int y, input int m);
    longint r;
    longint b;
    r = 1 % m;
    b = x % m;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return int'(r);
  endfunction

  function automatic int topBits(input int y);
    int k;
    k = 0;
    for (int i = 0; i < 8; i++) if (y[i]) k = i + 1;
    return k;
  endfunction

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   lat;
    logic busyOk;
    int   x, y, m;

    reset   = 1'b1;
    start8  = 1'b0; X8  = '0; Y8  = '0; M8  = '0;
    start16 = 1'b0; X16 = '0; Y16 = '0; M16 = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_P",    P8,    0);
    checkOutput("reset_busy", busy8, 0);
    checkOutput("reset_done", done8, 0);
    checkOutput("reset_err",  err8,  0);
    checkOutput("reset_P16",  P16,   0);
    reset = 1'b0;

    $display("[TB] basic 7^2 mod 10");
    applyStimulus8(8'd7, 8'd2, 8'd10);
    waitDone8(0, lat, busyOk);
    checkOutput("basic_lat",  lat,    25);
    checkOutput("basic_P",    P8,     9);
    checkOutput("basic_err",  err8,   0);
    checkOutput("basic_busy", busyOk, 1);

    $display("[TB] N=16 4^13 mod 497");
    applyStimulus16(16'd4, 16'd13, 16'd497);
    waitDone16(lat, busyOk);
    checkOutput("n16_lat",  lat,    81);
    checkOutput("n16_P",    P16,    445);
    checkOutput("n16_err",  err16,  0);
    checkOutput("n16_busy", busyOk, 1);
    repeat (5) @(negedge clk);
    checkOutput("n16_hold_P",    P16,    445);
    checkOutput("n16_hold_done", done16, 0);

    $display("[TB] boundaries");
    applyStimulus8(8'd255, 8'd255, 8'd251);
    waitDone8(0, lat, busyOk);
    checkOutput("max_lat", lat, 73);
    checkOutput("max_P",   P8,  20);

    applyStimulus8(8'd123, 8'd0, 8'd10);
    waitDone8(0, lat, busyOk);
    checkOutput("y0_lat", lat, 9);
    checkOutput("y0_P",   P8,  1);

    applyStimulus8(8'd200, 8'd77, 8'd1);
    waitDone8(0, lat, busyOk);
    checkOutput("m1_lat", lat, 65);
    checkOutput("m1_P",   P8,  0);

    applyStimulus8(8'd5, 8'd3, 8'd0);
    waitDone8(0, lat, busyOk);
    checkOutput("m0_lat", lat,  1);
    checkOutput("m0_err", err8, 1);
    checkOutput("m0_P",   P8,   0);

    applyStimulus8(8'd3, 8'd0, 8'd10);
    waitDone8(0, lat, busyOk);
    checkOutput("errclr_lat", lat,  9);
    checkOutput("errclr_err", err8, 0);
    checkOutput("errclr_P",   P8,   1);

    $display("[TB] start pulse mid-computation");
    applyStimulus8(8'd255, 8'd255, 8'd251);
    waitDone8(20, lat, busyOk);
    checkOutput("pulse_lat",  lat,    73);
    checkOutput("pulse_P",    P8,     20);
    checkOutput("pulse_busy", busyOk, 1);
    repeat (3) @(negedge clk);
    checkOutput("pulse_idle_busy", busy8, 0);

    $display("[TB] reset mid-computation");
    applyStimulus8(8'd255, 8'd255, 8'd251);
    repeat (10) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", busy8, 0);
    checkOutput("midrst_done", done8, 0);
    checkOutput("midrst_P",    P8,    0);
    reset = 1'b0;
    applyStimulus8(8'd7, 8'd2, 8'd10);
    waitDone8(0, lat, busyOk);
    checkOutput("afterrst_lat", lat, 25);
    checkOutput("afterrst_P",   P8,  9);

    $display("[TB] reference sweep");
    for (int n = 0; n < 300; n++) begin
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 255);
      m = $urandom_range(1, 255);
      applyStimulus8(8'(x), 8'(y), 8'(m));
      waitDone8(0, lat, busyOk);
      checkOutput("sweep_P",   P8,  modpow(x, y, m));
      checkOutput("sweep_lat", lat, 8 * (1 + topBits(y)) + 1);
      checkOutput("sweep_err", err8, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
